// File: rtl/pipeline_pkg.sv
// Shared types and default widths for the pipeline hazard/forwarding controller.
package pipeline_pkg;

   localparam int unsigned ADDRESSWIDTH_DEF = 4;
   localparam int unsigned REGNUM_DEF       = 2 ** ADDRESSWIDTH_DEF;

   typedef enum logic [1:0] {
      FWD_REG = 2'b00,
      FWD_WB  = 2'b01,
      FWD_M   = 2'b10
   } fwd_sel_t;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } mem_state_t;

endpackage

// File: rtl/hazard_match.sv
// Per-operand address comparator: forwarding hits from M/WB and load-use hit against E.
module hazard_match
   import pipeline_pkg::*;
#(
   parameter int unsigned ADDRESSWIDTH = ADDRESSWIDTH_DEF,
   parameter bit          ZEROREG      = 1'b0
) (
   input  logic [ADDRESSWIDTH-1:0] src_addr_d_i,
   input  logic                    src_used_d_i,
   input  logic [ADDRESSWIDTH-1:0] src_addr_e_i,
   input  logic                    src_used_e_i,
   input  logic [ADDRESSWIDTH-1:0] dest_addr_e_i,
   input  logic                    dest_is_load_e_i,
   input  logic [ADDRESSWIDTH-1:0] dest_addr_m_i,
   input  logic                    dest_wr_m_i,
   input  logic [ADDRESSWIDTH-1:0] dest_addr_wb_i,
   input  logic                    dest_wr_wb_i,
   output logic                    hit_m_o,
   output logic                    hit_wb_o,
   output logic                    hit_load_o
);

   logic src_e_live;
   logic src_d_live;

   // A hardwired-zero source never depends on an in-flight producer.
   assign src_e_live = src_used_e_i && !(ZEROREG && (src_addr_e_i == '0));
   assign src_d_live = src_used_d_i && !(ZEROREG && (src_addr_d_i == '0));

   assign hit_m_o    = src_e_live && dest_wr_m_i  && (dest_addr_m_i  == src_addr_e_i);
   assign hit_wb_o   = src_e_live && dest_wr_wb_i && (dest_addr_wb_i == src_addr_e_i);
   assign hit_load_o = src_d_live && dest_is_load_e_i && (dest_addr_e_i == src_addr_d_i);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage pipeline: forwarding, load-use,
// variable-latency memory wait FSM, branch flush priority and perf counters.
module pipeline_hazard_ctrl
   import pipeline_pkg::*;
#(
   parameter int unsigned ADDRESSWIDTH = ADDRESSWIDTH_DEF,
   parameter int unsigned NREAD        = 2,
   parameter bit          ZEROREG      = 1'b0,
   parameter int unsigned MAXWAIT      = 15,
   parameter int unsigned CNTWIDTH     = 16
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [NREAD*ADDRESSWIDTH-1:0] srcAddrD,
   input  logic [NREAD-1:0]              srcUsedD,
   input  logic [NREAD*ADDRESSWIDTH-1:0] srcAddrE,
   input  logic [NREAD-1:0]              srcUsedE,
   input  logic [ADDRESSWIDTH-1:0]       destAddrE,
   input  logic                          destIsLoadE,
   input  logic [ADDRESSWIDTH-1:0]       destAddrM,
   input  logic                          destWrM,
   input  logic [ADDRESSWIDTH-1:0]       destAddrWB,
   input  logic                          destWrWB,
   input  logic                          takeBranchE,
   input  logic                          memReqM,
   input  logic                          memAckM,
   output logic [2*NREAD-1:0]            fwdSelE,
   output logic                          stallF,
   output logic                          stallD,
   output logic                          stallE,
   output logic                          stallM,
   output logic                          flushD,
   output logic                          flushE,
   output logic                          flushWB,
   output logic                          memWait,
   output logic                          memTimeout,
   output logic [CNTWIDTH-1:0]           stallCount,
   output logic [CNTWIDTH-1:0]           flushCount
);

   localparam int unsigned WaitW = $clog2(MAXWAIT + 1);

   logic [NREAD-1:0]   hit_m, hit_wb, hit_load;
   logic [2*NREAD-1:0] fwd_sel;

   for (genvar gi = 0; gi < NREAD; gi++) begin : g_operand
      hazard_match #(
         .ADDRESSWIDTH (ADDRESSWIDTH),
         .ZEROREG      (ZEROREG)
      ) u_hazard_match (
         .src_addr_d_i     (srcAddrD[gi*ADDRESSWIDTH +: ADDRESSWIDTH]),
         .src_used_d_i     (srcUsedD[gi]),
         .src_addr_e_i     (srcAddrE[gi*ADDRESSWIDTH +: ADDRESSWIDTH]),
         .src_used_e_i     (srcUsedE[gi]),
         .dest_addr_e_i    (destAddrE),
         .dest_is_load_e_i (destIsLoadE),
         .dest_addr_m_i    (destAddrM),
         .dest_wr_m_i      (destWrM),
         .dest_addr_wb_i   (destAddrWB),
         .dest_wr_wb_i     (destWrWB),
         .hit_m_o          (hit_m[gi]),
         .hit_wb_o         (hit_wb[gi]),
         .hit_load_o       (hit_load[gi])
      );
      assign fwd_sel[2*gi +: 2] = hit_m[gi] ? FWD_M : (hit_wb[gi] ? FWD_WB : FWD_REG);
   end

   mem_state_t          state_q;
   logic [WaitW-1:0]    wait_cnt_q;
   logic                timeout_q;
   logic [CNTWIDTH-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNTWIDTH-1:0] flush_cnt_q, flush_cnt_d;
   logic                load_use, mem_stall, br_flush, stall_fd;

   always_comb begin
      load_use  = |hit_load;
      mem_stall = (state_q == WAIT) || (memReqM && !memAckM);
      br_flush  = takeBranchE && !mem_stall;
      // A taken branch squashes the load-use consumer, so it never stalls.
      stall_fd  = mem_stall || (load_use && !takeBranchE);
      stall_cnt_d = (stall_fd && (stall_cnt_q != '1)) ? stall_cnt_q + CNTWIDTH'(1) : stall_cnt_q;
      flush_cnt_d = (br_flush && (flush_cnt_q != '1)) ? flush_cnt_q + CNTWIDTH'(1) : flush_cnt_q;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         wait_cnt_q  <= '0;
         timeout_q   <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
         case (state_q)
            IDLE: begin
               wait_cnt_q <= '0;
               if (memReqM && !memAckM) state_q <= WAIT;
            end
            WAIT: begin
               if (memAckM) begin
                  state_q    <= IDLE;
                  wait_cnt_q <= '0;
               end else begin
                  if (wait_cnt_q != WaitW'(MAXWAIT)) wait_cnt_q <= wait_cnt_q + WaitW'(1);
                  // This is the MAXWAIT-th un-acked WAIT cycle; the FSM keeps waiting.
                  if (wait_cnt_q >= WaitW'(MAXWAIT - 1)) timeout_q <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Combinational outputs are masked so everything reads 0 while reset is held.
   assign fwdSelE    = reset ? fwd_sel : '0;
   assign stallF     = reset && stall_fd;
   assign stallD     = reset && stall_fd;
   assign stallE     = reset && mem_stall;
   assign stallM     = reset && mem_stall;
   assign flushWB    = reset && mem_stall;
   assign flushD     = reset && br_flush;
   assign flushE     = reset && (br_flush || (load_use && !mem_stall));
   assign memWait    = (state_q == WAIT);
   assign memTimeout = timeout_q;
   assign stallCount = stall_cnt_q;
   assign flushCount = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios plus randomized traffic vs a reference model.
module tb_pipeline_hazard_ctrl;

   logic       clock;
   logic       reset;
   logic [7:0] srcAddrD, srcAddrE;
   logic [1:0] srcUsedD, srcUsedE;
   logic [3:0] destAddrE, destAddrM, destAddrWB;
   logic       destIsLoadE, destWrM, destWrWB, takeBranchE, memReqM, memAckM;

   logic [3:0]  fwdSelE;
   logic        stallF, stallD, stallE, stallM, flushD, flushE, flushWB, memWait, memTimeout;
   logic [15:0] stallCount, flushCount;

   logic [3:0]  z_fwdSelE;
   logic        z_stallF, z_stallD, z_stallE, z_stallM, z_flushD, z_flushE, z_flushWB;
   logic        z_memWait, z_memTimeout;
   logic [2:0]  z_stallCount, z_flushCount;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state, one slot per DUT instance.
   bit          m_wait [2];
   int unsigned m_wcnt [2];
   bit          m_to   [2];
   int unsigned m_sc   [2];
   int unsigned m_fc   [2];

   pipeline_hazard_ctrl #(
      .ADDRESSWIDTH (4), .NREAD (2), .ZEROREG (1'b0), .MAXWAIT (15), .CNTWIDTH (16)
   ) u_dut (
      .clock (clock), .reset (reset),
      .srcAddrD (srcAddrD), .srcUsedD (srcUsedD), .srcAddrE (srcAddrE), .srcUsedE (srcUsedE),
      .destAddrE (destAddrE), .destIsLoadE (destIsLoadE),
      .destAddrM (destAddrM), .destWrM (destWrM), .destAddrWB (destAddrWB), .destWrWB (destWrWB),
      .takeBranchE (takeBranchE), .memReqM (memReqM), .memAckM (memAckM),
      .fwdSelE (fwdSelE), .stallF (stallF), .stallD (stallD), .stallE (stallE), .stallM (stallM),
      .flushD (flushD), .flushE (flushE), .flushWB (flushWB), .memWait (memWait),
      .memTimeout (memTimeout), .stallCount (stallCount), .flushCount (flushCount)
   );

   pipeline_hazard_ctrl #(
      .ADDRESSWIDTH (4), .NREAD (2), .ZEROREG (1'b1), .MAXWAIT (4), .CNTWIDTH (3)
   ) u_dut_z (
      .clock (clock), .reset (reset),
      .srcAddrD (srcAddrD), .srcUsedD (srcUsedD), .srcAddrE (srcAddrE), .srcUsedE (srcUsedE),
      .destAddrE (destAddrE), .destIsLoadE (destIsLoadE),
      .destAddrM (destAddrM), .destWrM (destWrM), .destAddrWB (destAddrWB), .destWrWB (destWrWB),
      .takeBranchE (takeBranchE), .memReqM (memReqM), .memAckM (memAckM),
      .fwdSelE (z_fwdSelE), .stallF (z_stallF), .stallD (z_stallD), .stallE (z_stallE),
      .stallM (z_stallM), .flushD (z_flushD), .flushE (z_flushE), .flushWB (z_flushWB),
      .memWait (z_memWait), .memTimeout (z_memTimeout),
      .stallCount (z_stallCount), .flushCount (z_flushCount)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic bit zr_of(input int k);
      return k == 1;
   endfunction

   function automatic int unsigned maxwait_of(input int k);
      return (k == 0) ? 15 : 4;
   endfunction

   function automatic int unsigned cmax_of(input int k);
      return (k == 0) ? 65535 : 7;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_wait[k] = 1'b0;
         m_wcnt[k] = 0;
         m_to[k]   = 1'b0;
         m_sc[k]   = 0;
         m_fc[k]   = 0;
      end
   endtask

   // Expected combinational outputs: fwd per operand, stalls {F,D,E,M}, flushes {D,E,WB}.
   task automatic model_out(input int k, output logic [3:0] fwd, output logic [3:0] st,
                            output logic [2:0] fl);
      logic [3:0] a;
      logic [1:0] sel;
      logic       lu, ms, br, sfd;
      fwd = '0;
      st  = '0;
      fl  = '0;
      if (reset === 1'b1) begin
         lu = 1'b0;
         for (int i = 0; i < 2; i++) begin
            a   = srcAddrE[4*i +: 4];
            sel = 2'd0;
            if (srcUsedE[i] && !(zr_of(k) && a == 4'd0)) begin
               if (destWrM && a == destAddrM)        sel = 2'd2;
               else if (destWrWB && a == destAddrWB) sel = 2'd1;
            end
            fwd[2*i +: 2] = sel;
            a = srcAddrD[4*i +: 4];
            if (destIsLoadE && srcUsedD[i] && a == destAddrE && !(zr_of(k) && a == 4'd0))
               lu = 1'b1;
         end
         ms  = m_wait[k] || (memReqM && !memAckM);
         br  = takeBranchE && !ms;
         sfd = ms || (lu && !br);
         st  = {sfd, sfd, ms, ms};
         fl  = {br, br || (lu && !ms), ms};
      end
   endtask

   task automatic model_tick(input int k);
      logic [3:0] fwd, st;
      logic [2:0] fl;
      if (reset !== 1'b1) begin
         m_wait[k] = 1'b0;
         m_wcnt[k] = 0;
         m_to[k]   = 1'b0;
         m_sc[k]   = 0;
         m_fc[k]   = 0;
      end else begin
         model_out(k, fwd, st, fl);
         if (st[3] && m_sc[k] < cmax_of(k)) m_sc[k]++;
         if (fl[2] && m_fc[k] < cmax_of(k)) m_fc[k]++;
         if (m_wait[k]) begin
            if (memAckM) begin
               m_wait[k] = 1'b0;
               m_wcnt[k] = 0;
            end else begin
               m_wcnt[k]++;
               if (m_wcnt[k] >= maxwait_of(k)) m_to[k] = 1'b1;
            end
         end else if (memReqM && !memAckM) begin
            m_wait[k] = 1'b1;
            m_wcnt[k] = 0;
         end
      end
   endtask

   task automatic cmp_inst(input int k, input logic [3:0] fwd, input logic [3:0] st,
                           input logic [2:0] fl, input logic mw, input logic to,
                           input logic [31:0] sc, input logic [31:0] fc);
      logic [3:0] e_fwd, e_st;
      logic [2:0] e_fl;
      model_out(k, e_fwd, e_st, e_fl);
      check_eq($sformatf("fwd%0d", k),   32'(fwd), 32'(e_fwd));
      check_eq($sformatf("stall%0d", k), 32'(st),  32'(e_st));
      check_eq($sformatf("flush%0d", k), 32'(fl),  32'(e_fl));
      check_eq($sformatf("wait%0d", k),  32'(mw),  32'(m_wait[k]));
      check_eq($sformatf("tmo%0d", k),   32'(to),  32'(m_to[k]));
      check_eq($sformatf("scnt%0d", k),  sc,       m_sc[k]);
      check_eq($sformatf("fcnt%0d", k),  fc,       m_fc[k]);
   endtask

   task automatic compare_all();
      cmp_inst(0, fwdSelE, {stallF, stallD, stallE, stallM}, {flushD, flushE, flushWB},
               memWait, memTimeout, 32'(stallCount), 32'(flushCount));
      cmp_inst(1, z_fwdSelE, {z_stallF, z_stallD, z_stallE, z_stallM},
               {z_flushD, z_flushE, z_flushWB}, z_memWait, z_memTimeout,
               32'(z_stallCount), 32'(z_flushCount));
   endtask

   // Inputs change at posedge+1; outputs are compared at the falling edge.
   task automatic cycle();
      @(negedge clock);
      compare_all();
      @(posedge clock);
      model_tick(0);
      model_tick(1);
      #1;
   endtask

   task automatic idle_inputs();
      srcAddrD = '0; srcAddrE = '0; srcUsedD = '0; srcUsedE = '0;
      destAddrE = '0; destIsLoadE = 1'b0; destAddrM = '0; destWrM = 1'b0;
      destAddrWB = '0; destWrWB = 1'b0; takeBranchE = 1'b0; memReqM = 1'b0; memAckM = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      model_reset();
      @(posedge clock);
      @(posedge clock);
      #1;
      reset = 1'b1;
   endtask

   function automatic logic [3:0] rand_addr();
      if ($urandom_range(0, 3) == 0) return 4'($urandom_range(0, 15));
      return 4'($urandom_range(0, 3));
   endfunction

   initial begin
      reset = 1'b0;
      idle_inputs();
      model_reset();
      // Reset state with live-looking inputs: every output must still read 0.
      memReqM = 1'b1; takeBranchE = 1'b1; srcUsedE = 2'b11; destWrM = 1'b1;
      #3;
      check_eq("rst_fwd", 32'(fwdSelE), 32'd0);
      check_eq("rst_stall", 32'({stallF, stallD, stallE, stallM}), 32'd0);
      check_eq("rst_flush", 32'({flushD, flushE, flushWB}), 32'd0);
      check_eq("rst_cnt", 32'(stallCount) + 32'(flushCount), 32'd0);
      idle_inputs();
      do_reset();

      // Forwarding priority M over WB, then WB alone.
      srcAddrE = 8'h03; srcUsedE = 2'b01; destWrM = 1'b1; destAddrM = 4'd3;
      destWrWB = 1'b1; destAddrWB = 4'd3;
      #1 check_eq("t1_fwd_m", 32'(fwdSelE[1:0]), 32'd2);
      cycle();
      destWrM = 1'b0;
      #1 check_eq("t1_fwd_wb", 32'(fwdSelE[1:0]), 32'd1);
      cycle();
      // Register 0 is forwarded only where it is not hardwired.
      srcAddrE = 8'h00; destWrM = 1'b1; destAddrM = 4'd0;
      #1 check_eq("zr_fwd_main", 32'(fwdSelE[1:0]), 32'd2);
      check_eq("zr_fwd_zero", 32'(z_fwdSelE[1:0]), 32'd0);
      cycle();
      idle_inputs();

      // Load-use on operand 1.
      do_reset();
      destIsLoadE = 1'b1; destAddrE = 4'd5; srcAddrD = 8'h50; srcUsedD = 2'b10;
      #1 check_eq("t2_lu", 32'({stallF, stallD, flushE, stallE}), 32'b1110);
      cycle();
      idle_inputs();
      #1 check_eq("t2_cnt", 32'(stallCount), 32'd1);
      check_eq("t2_release", 32'(stallF), 32'd0);
      cycle();

      // Memory miss acked three cycles later.
      do_reset();
      memReqM = 1'b1;
      #1 check_eq("t3_miss", 32'({stallF, stallD, stallE, stallM, flushWB, memWait}), 32'b111110);
      cycle();
      for (int i = 1; i <= 3; i++) begin
         memAckM = (i == 3);
         #1 check_eq("t3_wait", 32'({memWait, stallM, flushWB}), 32'b111);
         cycle();
      end
      idle_inputs();
      #1 check_eq("t3_idle", 32'({memWait, stallF}), 32'd0);
      check_eq("t3_cnt", 32'(stallCount), 32'd4);
      cycle();

      // Zero-wait access.
      do_reset();
      memReqM = 1'b1; memAckM = 1'b1;
      #1 check_eq("t4_nostall", 32'(stallF), 32'd0);
      cycle();
      idle_inputs();
      #1 check_eq("t4_idle", 32'(memWait), 32'd0);
      cycle();

      // Branch held under a memory stall, then branch beating load-use.
      do_reset();
      memReqM = 1'b1; takeBranchE = 1'b1;
      #1 check_eq("t5_hold_miss", 32'({flushD, flushE}), 32'd0);
      cycle();
      #1 check_eq("t5_hold_wait", 32'({flushD, flushE}), 32'd0);
      cycle();
      memAckM = 1'b1;
      #1 check_eq("t5_hold_ack", 32'({flushD, stallF}), 32'b01);
      cycle();
      memReqM = 1'b0; memAckM = 1'b0;
      #1 check_eq("t5_flush", 32'({flushD, flushE, stallF}), 32'b110);
      cycle();
      takeBranchE = 1'b0;
      #1 check_eq("t5_fcnt", 32'(flushCount), 32'd1);
      cycle();
      takeBranchE = 1'b1; destIsLoadE = 1'b1; destAddrE = 4'd7; srcAddrD = 8'h07;
      srcUsedD = 2'b01;
      #1 check_eq("t5_br_lu", 32'({flushD, flushE, stallF, stallD}), 32'b1100);
      cycle();
      idle_inputs();

      // Timeout with no ack, then asynchronous reset mid-WAIT.
      do_reset();
      memReqM = 1'b1;
      #1;
      cycle();
      for (int i = 1; i <= 15; i++) begin
         if (i == 15) check_eq("t6_tmo_early", 32'(memTimeout), 32'd0);
         cycle();
      end
      check_eq("t6_tmo_set", 32'({memTimeout, memWait}), 32'b11);
      cycle();
      cycle();
      check_eq("t6_tmo_sticky", 32'(memTimeout), 32'd1);
      check_eq("t6_sat", 32'(z_stallCount), 32'd7);
      srcAddrE = 8'h33; srcUsedE = 2'b11; destWrM = 1'b1; destAddrM = 4'd3;
      destIsLoadE = 1'b1; srcUsedD = 2'b11; takeBranchE = 1'b1;
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      check_eq("t6_rst_wait", 32'({memWait, memTimeout, z_memWait, z_memTimeout}), 32'd0);
      check_eq("t6_rst_fwd", 32'(fwdSelE), 32'd0);
      check_eq("t6_rst_ctl", 32'({stallF, stallD, stallE, stallM, flushD, flushE, flushWB}), 32'd0);
      check_eq("t6_rst_cnt", 32'(stallCount), 32'd0);
      cycle();
      idle_inputs();
      reset = 1'b1;
      cycle();

      // Randomized traffic against the model, with occasional reset pulses.
      for (int n = 0; n < 3000; n++) begin
         reset = ($urandom_range(0, 199) != 0);
         if (!reset) model_reset();
         srcAddrD    = {rand_addr(), rand_addr()};
         srcAddrE    = {rand_addr(), rand_addr()};
         srcUsedD    = 2'($urandom_range(0, 3));
         srcUsedE    = 2'($urandom_range(0, 3));
         destAddrE   = rand_addr();
         destAddrM   = rand_addr();
         destAddrWB  = rand_addr();
         destIsLoadE = ($urandom_range(0, 2) == 0);
         destWrM     = ($urandom_range(0, 1) == 0);
         destWrWB    = ($urandom_range(0, 1) == 0);
         takeBranchE = ($urandom_range(0, 4) == 0);
         memReqM     = ($urandom_range(0, 9) < 3);
         memAckM     = ($urandom_range(0, 9) < 3);
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
